i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
// - Sink for the 24-bit audio sample stream produced by the synth core (oscillator/waveform-select
//   output). Serialises stereo sample pairs onto an I2S bus (bclk/lrclk/sdata) toward the DAC.
// - Single system clock. BCLK and LRCLK are derived internally.
// - Single-entry holding buffer with valid/ready handshake; zero-fill plus flag on underrun.
// PARAMETERS
// - WIDTH_P      24  sample width in bits; legal range 1..SLOT_BITS_P
// - SLOT_BITS_P  32  BCLK periods per channel slot; frame length = 2*SLOT_BITS_P
// - BCLK_DIV_P   2   clk_i cycles per BCLK half-period; must be >= 1
//                    (12.288 MHz / 4 = 3.072 MHz = 64 * 48 kHz)
// PORTS
// - clk_i       in   1        system clock
// - rst_ni      in   1        asynchronous reset, active low
// - left_i      in   WIDTH_P  left sample, two's complement
// - right_i     in   WIDTH_P  right sample, two's complement (tie to left_i for mono)
// - valid_i     in   1        left_i/right_i hold a valid pair
// - ready_o     out  1        holding buffer empty; a pair is accepted when valid_i && ready_o
// - bclk_o      out  1        I2S bit clock
// - lrclk_o     out  1        I2S word select; 0 = left, 1 = right
// - sdata_o     out  1        I2S serial data; changes on BCLK falling edge
// - underrun_o  out  1        one-cycle pulse: frame started while the buffer was empty
// BEHAVIOUR
// - Reset values: div_q=0, bclk_o=0, bit_q=2*SLOT_BITS_P-1, lrclk_o=1, sdata_o=0, shreg=0,
//   full_q=0, ready_o=1, underrun_o=0. Every output is registered, except ready_o = !full_q.
// - Divider
//   - div_q counts 0..BCLK_DIV_P-1. At the terminal count it wraps to 0 and bclk_o toggles.
//   - A "fall event" is the cycle in which bclk_o is registered 1->0.
//   - With the reset values, the first fall event occurs 2*BCLK_DIV_P cycles after reset release.
// - Bit position
//   - On each fall event, bit_q increments modulo 2*SLOT_BITS_P.
//   - A fall event on which bit_q wraps to 0 is a "frame event".
//   - lrclk_o <= (new bit_q >= SLOT_BITS_P), updated on the same fall event.
// - Frame event, all in the same clk_i cycle:
//   - If full_q=1: load shreg = {hold_L, (SLOT-WIDTH) zeros, hold_R, (SLOT-WIDTH) zeros},
//     MSB first, and clear full_q.
//   - If full_q=0: load shreg = all zeros and pulse underrun_o.
// - Data (I2S one-bit delay)
//   - On every fall event, sdata_o <= shreg[2*SLOT_BITS_P-1], then shreg shifts left by 1
//     with 0 shifted in.
//   - On a frame event, sdata_o takes the MSB of the old shreg (the final bit of the previous
//     frame), and the new frame is loaded rather than shifted.
//   - Result: left MSB appears one BCLK after lrclk_o falls; right MSB appears one BCLK after
//     lrclk_o rises.
// - Handshake
//   - When valid_i && ready_o: capture hold_L/hold_R <= left_i/right_i; full_q <= 1.
//   - Input may change freely while ready_o=0.
//   - Capture on the same cycle as a frame event with full_q=0: the frame event loads zeros and
//     pulses underrun_o; the captured pair is sent on the next frame. No combinational bypass.
//   - Capture on the same cycle as a frame event with full_q=1: impossible, since ready_o=0.
// - Throughput: one pair per 2*SLOT_BITS_P*2*BCLK_DIV_P clk cycles (256 at defaults).
// - Reset asserted mid-frame: all state returns to reset values immediately (asynchronous).
//   The partial frame and the buffered pair are discarded. No sample is output until a new
//   pair is accepted.
// TESTING
// - Reset: hold rst_ni=0 for 10 cycles -> bclk_o=0, lrclk_o=1, sdata_o=0, ready_o=1,
//   underrun_o=0; release -> first bclk_o rise after 2 cycles (defaults).
// - Clocking: defaults, free run -> bclk_o period 4 clk_i cycles, 50% duty; lrclk_o period
//   256 cycles, 128 low / 128 high; lrclk_o edges coincide with bclk_o falling edges.
// - Data: accept L=24'hA5A5A5, R=24'h5A5A5A before a frame event -> sampled on bclk_o rising
//   edges after lrclk_o falls: 1 pad bit, then 24 bits 0xA5A5A5, then 8 zeros; the right slot
//   follows likewise with 0x5A5A5A. No underrun_o in that frame.
// - Backpressure: present two pairs back-to-back -> the first is accepted; ready_o=0 until
//   the next frame event, then 1; the second pair is accepted and sent in the following frame.
// - Underrun: no valid_i for 3 frames -> sdata_o constantly 0; exactly 3 underrun_o pulses,
//   each one cycle wide, on the frame-event cycles. Capture exactly on a frame event -> underrun
//   pulse in that frame, pair sent in the next frame.
// - Reset mid-frame: assert rst_ni=0 at bit 40 with a pair buffered -> reset values at once;
//   after release, zeros and an underrun_o pulse in the first frame.
// - Parameters: WIDTH_P=16, SLOT_BITS_P=16, BCLK_DIV_P=1 -> 32-bit frames; bclk_o period
//   2 cycles; no pad bits.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers one stereo pair behind a valid/ready handshake and
// serialises it MSB first with the standard one-BCLK data delay after LRCLK.
module i2s_tx #(
    parameter int WIDTH_P     = 24,
    parameter int SLOT_BITS_P = 32,
    parameter int BCLK_DIV_P  = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH_P-1:0] left_i,
    input  logic [WIDTH_P-1:0] right_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               bclk_o,
    output logic               lrclk_o,
    output logic               sdata_o,
    output logic               underrun_o
);

    localparam int FRAME_BITS = 2 * SLOT_BITS_P;
    localparam int DIV_W      = (BCLK_DIV_P > 1) ? $clog2(BCLK_DIV_P) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    logic        [DIV_W-1:0]      div_q;
    logic        [BIT_W-1:0]      bit_q;
    logic        [BIT_W-1:0]      bit_d;
    logic        [FRAME_BITS-1:0] shreg_q;
    logic                         full_q;
    logic signed [WIDTH_P-1:0]    hold_l_q;
    logic signed [WIDTH_P-1:0]    hold_r_q;
    logic                         div_wrap;
    logic                         fall;
    logic                         frame;
    logic                         accept;

    // Left-justify each sample in its slot; the remaining LSBs are zero pad.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic signed [WIDTH_P-1:0] l,
        input logic signed [WIDTH_P-1:0] r
    );
        logic [SLOT_BITS_P-1:0] slot_l;
        logic [SLOT_BITS_P-1:0] slot_r;
        slot_l = '0;
        slot_r = '0;
        slot_l[SLOT_BITS_P-1 -: WIDTH_P] = l;
        slot_r[SLOT_BITS_P-1 -: WIDTH_P] = r;
        return {slot_l, slot_r};
    endfunction

    assign div_wrap = (div_q == DIV_W'(BCLK_DIV_P - 1));
    assign fall     = div_wrap && bclk_o;
    assign frame    = fall && (bit_q == BIT_W'(FRAME_BITS - 1));
    assign bit_d    = frame ? '0 : bit_q + BIT_W'(1);
    assign ready_o  = !full_q;
    assign accept   = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q      <= '0;
            bclk_o     <= 1'b0;
            bit_q      <= BIT_W'(FRAME_BITS - 1);
            lrclk_o    <= 1'b1;
            sdata_o    <= 1'b0;
            shreg_q    <= '0;
            full_q     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= frame && !full_q;
            if (div_wrap) begin
                div_q  <= '0;
                bclk_o <= !bclk_o;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            // Bit position, word select and data all advance on the BCLK fall.
            if (fall) begin
                bit_q   <= bit_d;
                lrclk_o <= (bit_d >= BIT_W'(SLOT_BITS_P));
                sdata_o <= shreg_q[FRAME_BITS-1];
                if (frame) begin
                    shreg_q <= full_q ? pack_frame(hold_l_q, hold_r_q) : '0;
                end else begin
                    shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            // Accept and frame-load are exclusive: accept needs full_q=0, unload needs full_q=1.
            if (accept) begin
                full_q <= 1'b1;
            end else if (frame) begin
                full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            hold_l_q <= left_i;
            hold_r_q <= right_i;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: default instance plus a 16/16/1 instance.
module tb_i2s_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] left, right;
    logic        valid, ready, bclk, lrclk, sdata, underrun;

    logic        rst2_n;
    logic [15:0] left2, right2;
    logic        valid2, ready2, bclk2, lrclk2, sdata2, underrun2;

    i2s_tx dut (
        .clk_i(clk), .rst_ni(rst_n), .left_i(left), .right_i(right), .valid_i(valid),
        .ready_o(ready), .bclk_o(bclk), .lrclk_o(lrclk), .sdata_o(sdata), .underrun_o(underrun)
    );

    i2s_tx #(.WIDTH_P(16), .SLOT_BITS_P(16), .BCLK_DIV_P(1)) dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .left_i(left2), .right_i(right2), .valid_i(valid2),
        .ready_o(ready2), .bclk_o(bclk2), .lrclk_o(lrclk2), .sdata_o(sdata2), .underrun_o(underrun2)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ur_total = 0;

    always @(negedge clk) begin
        if (underrun === 1'b1) ur_total <= ur_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Values recorded at the cycle lrclk falls.
    logic fall_prev_bclk, fall_bclk, ready_before, ready_at, ur_at;

    task automatic wait_lr_fall();
        logic pl, pb, pr;
        pl = lrclk; pb = bclk; pr = ready;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (pl && !lrclk) begin
                fall_prev_bclk = pb; fall_bclk = bclk;
                ready_before = pr; ready_at = ready; ur_at = underrun;
                return;
            end
            pl = lrclk; pb = bclk; pr = ready;
        end
        check("lr_fall_timeout", 1, 0);
    endtask

    // Sample sdata on the 64 bclk rises that follow the next lrclk fall.
    task automatic capture(output logic [63:0] w);
        logic pb;
        int   n;
        w = '0;
        wait_lr_fall();
        pb = bclk;
        n  = 0;
        for (int i = 0; i < 400 && n < 64; i++) begin
            @(negedge clk);
            if (!pb && bclk) begin
                w = {w[62:0], sdata};
                n++;
            end
            pb = bclk;
        end
        check("cap_bits", n, 64);
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        left = l; right = r; valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (ready) begin
                @(negedge clk);
                valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check("send_timeout", 1, 0);
    endtask

    // Leading bit is the previous frame's final (zero) bit, then L, pad, R, pad.
    function automatic logic [63:0] exp_word(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = {l, 8'h00, r, 8'h00};
        return f >> 1;
    endfunction

    initial begin
        logic [63:0] w;
        logic [31:0] w2;
        int lr_low, lr_high, b_high, rises, last_rise, min_iv, max_iv, ur0, n2, lr2_low;
        logic pb, pl;

        rst_n = 1'b0; rst2_n = 1'b0; valid = 1'b0; left = '0; right = '0;
        valid2 = 1'b0; left2 = '0; right2 = '0;
        repeat (10) @(negedge clk);
        check("rst_bclk", bclk, 0);
        check("rst_lrclk", lrclk, 1);
        check("rst_sdata", sdata, 0);
        check("rst_ready", ready, 1);
        check("rst_underrun", underrun, 0);

        rst_n = 1'b1;
        @(negedge clk); check("bclk_c1", bclk, 0);
        @(negedge clk); check("bclk_c2", bclk, 1);
        @(negedge clk); check("bclk_c3", bclk, 1);
        @(negedge clk);
        check("bclk_c4", bclk, 0);
        check("lrclk_c4", lrclk, 0);
        check("underrun_c4", underrun, 1);

        // Free-run clock measurements over one 256-cycle frame.
        lr_low = 1; lr_high = 0; b_high = 0; rises = 0; last_rise = -1; min_iv = 999; max_iv = 0;
        pb = bclk; pl = lrclk;
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            if (lrclk) lr_high++; else lr_low++;
            if (bclk) b_high++;
            if (!pb && bclk) begin
                rises++;
                if (last_rise >= 0) begin
                    if (i - last_rise < min_iv) min_iv = i - last_rise;
                    if (i - last_rise > max_iv) max_iv = i - last_rise;
                end
                last_rise = i;
            end
            pb = bclk; pl = lrclk;
        end
        @(negedge clk);
        check("lr_low_cycles", lr_low, 128);
        check("lr_high_cycles", lr_high, 128);
        check("bclk_high_cycles", b_high, 128);
        check("bclk_rises", rises, 64);
        check("bclk_period_min", min_iv, 4);
        check("bclk_period_max", max_iv, 4);
        check("lr_fall_prev_lr", pl, 1);
        check("lr_fall_lr", lrclk, 0);
        check("lr_fall_prev_bclk", pb, 1);
        check("lr_fall_bclk", bclk, 0);

        // Data frame.
        send(24'hA5A5A5, 24'h5A5A5A);
        ur0 = ur_total;
        capture(w);
        check("data_a5", w, {1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00});
        check("data_ur_at_fall", ur_at, 0);
        check("data_ur_count", ur_total - ur0, 0);

        // Backpressure: second pair waits for the frame event that drains the first.
        repeat (20) @(negedge clk);
        ur0 = ur_total;
        send(24'h123456, 24'h654321);
        check("bp_ready_low", ready, 0);
        left = 24'hABCDEF; right = 24'hFEDCBA; valid = 1'b1;
        capture(w);
        valid = 1'b0;
        check("bp_ready_before", ready_before, 0);
        check("bp_ready_at", ready_at, 1);
        check("bp_frame1", w, exp_word(24'h123456, 24'h654321));
        check("bp_ready_held", ready, 0);
        capture(w);
        check("bp_frame2", w, exp_word(24'hABCDEF, 24'hFEDCBA));
        check("bp_ur_count", ur_total - ur0, 0);

        // Three empty frames.
        ur0 = ur_total;
        for (int k = 0; k < 3; k++) begin
            capture(w);
            check("ur_zero_data", w, 0);
            check("ur_at_fall", ur_at, 1);
        end
        check("ur_count", ur_total - ur0, 3);

        // Capture coinciding with a frame event.
        @(negedge clk);
        left = 24'h800001; right = 24'h7FFFFE; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("fe_underrun", underrun, 1);
        check("fe_lrclk", lrclk, 0);
        check("fe_ready", ready, 0);
        capture(w);
        check("fe_data", w, {1'b0, 24'h800001, 8'h00, 24'h7FFFFE, 7'h00});
        check("fe_ur_at_fall", ur_at, 0);

        // Reset mid-frame with a pair buffered.
        repeat (4) @(negedge clk);
        send(24'h111111, 24'h222222);
        repeat (159) @(negedge clk);
        check("mid_ready_pre", ready, 0);
        check("mid_lrclk_pre", lrclk, 1);
        check("mid_bclk_pre", bclk, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_bclk", bclk, 0);
        check("mid_rst_lrclk", lrclk, 1);
        check("mid_rst_sdata", sdata, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_underrun", underrun, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ur0 = ur_total;
        capture(w);
        check("mid_post_data", w, 0);
        check("mid_post_ur_at", ur_at, 1);
        check("mid_post_ur_count", ur_total - ur0, 1);

        // 16-bit samples, 16-bit slots, divider of 1.
        check("p2_rst_bclk", bclk2, 0);
        check("p2_rst_lrclk", lrclk2, 1);
        check("p2_rst_ready", ready2, 1);
        left2 = 16'hBEEF; right2 = 16'h1234; valid2 = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
        check("p2_bclk_c1", bclk2, 1);
        check("p2_ready_c1", ready2, 0);
        valid2 = 1'b0;
        @(negedge clk);
        check("p2_bclk_c2", bclk2, 0);
        check("p2_lrclk_c2", lrclk2, 0);
        check("p2_underrun_c2", underrun2, 0);
        pb = bclk2; n2 = 0; w2 = '0; lr2_low = 1;
        for (int i = 0; i < 200 && n2 < 32; i++) begin
            @(negedge clk);
            if (!lrclk2) lr2_low++;
            if (!pb && bclk2) begin
                w2 = {w2[30:0], sdata2};
                n2++;
            end
            pb = bclk2;
        end
        check("p2_bits", n2, 32);
        check("p2_data", w2, 32'h5F77891A);
        check("p2_lr_low", lr2_low, 32);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
